// File: rtl/mem_access_unit.sv
// Load/store request stage: issues word-aligned memory requests and hands raw load words to the mask stage.
// Define MEM_TIMEOUT_EN to add a RESP watchdog and the mem_timeout output.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_rdata_valid,
    input  logic [31:0] mem_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [5:0]  ld_opcode,
    output logic [1:0]  ld_byte_offset,
    output logic        st_done,
    output logic        addr_misaligned,
`ifdef MEM_TIMEOUT_EN
    output logic        mem_timeout,
`endif
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    state_t      state_q;
    logic        req_valid_q;
    logic [31:0] addr_q;
    logic [3:0]  we_q;
    logic [31:0] wdata_q;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic        store_q;
    logic        ld_valid_q;
    logic [31:0] ld_data_q;
    logic [5:0]  ld_op_q;
    logic [1:0]  ld_off_q;
    logic        st_done_q;
    logic        misal_q;

    logic        is_load_d;
    logic        is_store_d;
    logic        misal_d;
    logic [3:0]  we_d;
    logic [31:0] wdata_d;
    logic [1:0]  off_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    assign mem_timeout = timeout_q;
`else
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
`endif

    // Big-endian lane mapping: byte address 0 lives in bits 31:24 (we[3]).
    always_comb begin
        is_load_d  = 1'b0;
        is_store_d = 1'b0;
        misal_d    = 1'b0;
        we_d       = 4'b0000;
        wdata_d    = store_data;
        off_d      = 2'b00;
        case (opcode)
            OP_LB, OP_LBU: begin
                is_load_d = 1'b1;
                off_d     = addr[1:0];
            end
            OP_LH, OP_LHU: begin
                is_load_d = 1'b1;
                misal_d   = addr[0];
                off_d     = {1'b0, addr[1]};
            end
            OP_LW: begin
                is_load_d = 1'b1;
                misal_d   = |addr[1:0];
            end
            OP_SB: begin
                is_store_d = 1'b1;
                we_d       = 4'b1000 >> addr[1:0];
                wdata_d    = {4{store_data[7:0]}};
            end
            OP_SH: begin
                is_store_d = 1'b1;
                misal_d    = addr[0];
                we_d       = addr[1] ? 4'b0011 : 4'b1100;
                wdata_d    = {2{store_data[15:0]}};
            end
            OP_SW: begin
                is_store_d = 1'b1;
                misal_d    = |addr[1:0];
                we_d       = 4'b1111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= '0;
            wdata_q     <= '0;
            op_q        <= '0;
            off_q       <= '0;
            store_q     <= 1'b0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            ld_op_q     <= '0;
            ld_off_q    <= '0;
            st_done_q   <= 1'b0;
            misal_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            ld_valid_q <= 1'b0;
            st_done_q  <= 1'b0;
            misal_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    // Non-memory opcodes fall through both branches and are dropped.
                    if (issue_valid) begin
                        if (misal_d) begin
                            misal_q <= 1'b1;
                        end else if (is_load_d || is_store_d) begin
                            addr_q      <= {addr[31:2], 2'b00};
                            we_q        <= we_d;
                            wdata_q     <= wdata_d;
                            op_q        <= opcode;
                            off_q       <= off_d;
                            store_q     <= is_store_d;
                            req_valid_q <= 1'b1;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        if (store_q) begin
                            st_done_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            state_q <= S_RESP;
`ifdef MEM_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end
                end
                S_RESP: begin
                    if (mem_rdata_valid) begin
                        ld_valid_q <= 1'b1;
                        ld_data_q  <= mem_rdata;
                        ld_op_q    <= op_q;
                        ld_off_q   <= off_q;
                        state_q    <= S_IDLE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        ld_valid_q <= 1'b1;
                        ld_data_q  <= 32'hDEADBEEF;
                        ld_op_q    <= op_q;
                        ld_off_q   <= off_q;
                        timeout_q  <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign issue_ready     = (state_q == S_IDLE);
    assign mem_req_valid   = req_valid_q;
    assign mem_addr        = addr_q;
    assign mem_we          = we_q;
    assign mem_wdata       = wdata_q;
    assign ld_valid        = ld_valid_q;
    assign ld_data         = ld_data_q;
    assign ld_opcode       = ld_op_q;
    assign ld_byte_offset  = ld_off_q;
    assign st_done         = st_done_q;
    assign addr_misaligned = misal_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: stimulus table, randomized transactions against a
// byte-lane reference model, and reset/timeout sequences.
module tb_mem_access_unit;

    localparam int TO = 4;

    // Handshake rules: a request transfers on a rising edge where mem_req_valid and
    // mem_req_ready are both high; mem_req_valid and its payload hold until then.

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_rdata_valid;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [5:0]  ld_opcode;
    logic [1:0]  ld_byte_offset;
    logic        st_done;
    logic        addr_misaligned;
    logic [1:0]  dbg_state;
`ifdef MEM_TIMEOUT_EN
    logic        mem_timeout;
`endif

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .opcode          (opcode),
        .addr            (addr),
        .store_data      (store_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_wdata       (mem_wdata),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata),
        .ld_valid        (ld_valid),
        .ld_data         (ld_data),
        .ld_opcode       (ld_opcode),
        .ld_byte_offset  (ld_byte_offset),
        .st_done         (st_done),
        .addr_misaligned (addr_misaligned),
`ifdef MEM_TIMEOUT_EN
        .mem_timeout     (mem_timeout),
`endif
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 none, 1 load, 2 store
        bit          mis;
        logic [31:0] maddr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [1:0]  off;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          rdly;
        int          ddly;
        exp_t        e;
    } vec_t;

    typedef struct {
        int          req_cnt;
        logic [31:0] req_addr;
        logic [3:0]  req_we;
        logic [31:0] req_wdata;
        bit          stable;
        int          mis_cnt;
        int          st_cnt;
        int          st_k;
        int          ld_cnt;
        int          ld_k;
        logic [5:0]  ld_op;
        logic [1:0]  ld_off;
        int          to_cnt;
        bit          done;
    } obs_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    vec_t        vecs[$];
    logic [31:0] mdl_data = '0;
    logic [5:0]  mdl_op = '0;
    logic [1:0]  mdl_off = '0;
    logic [5:0]  ops[11] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                             6'h00, 6'h22, 6'h3F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: an access of `size` bytes at byte address a touches big-endian lanes 3-a%4 ...
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd);
        exp_t e;
        int   size;
        int   lo;
        e    = '{default: 0};
        size = 0;
        case (op)
            6'h20, 6'h24: begin e.kind = 1; size = 1; end
            6'h21, 6'h25: begin e.kind = 1; size = 2; end
            6'h23:        begin e.kind = 1; size = 4; end
            6'h28:        begin e.kind = 2; size = 1; end
            6'h29:        begin e.kind = 2; size = 2; end
            6'h2B:        begin e.kind = 2; size = 4; end
            default: ;
        endcase
        if (size == 0) return e;
        lo      = int'(a[1:0]);
        e.mis   = (lo % size) != 0;
        e.maddr = a - 32'(lo);
        if (e.kind == 2 && !e.mis)
            for (int b = lo; b < lo + size; b++) e.we[3 - b] = 1'b1;
        for (int j = 0; j < 4; j++) e.wdata[8*j +: 8] = sd[8*(j % size) +: 8];
        e.off = (size == 1) ? 2'(lo) : ((size == 2) ? 2'(lo / 2) : 2'd0);
        return e;
    endfunction

    function automatic exp_t mk(input int kind, input bit mis, input logic [31:0] maddr,
                                input logic [3:0] we, input logic [31:0] wdata, input logic [1:0] off);
        exp_t e;
        e.kind = kind; e.mis = mis; e.maddr = maddr; e.we = we; e.wdata = wdata; e.off = off;
        return e;
    endfunction

    task automatic add_vec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int rdly, input int ddly, input exp_t e);
        vec_t v;
        v.op = op; v.addr = a; v.sd = sd; v.rdata = rd; v.rdly = rdly; v.ddly = ddly; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        issue_valid = 1'b0; mem_req_ready = 1'b0; mem_rdata_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mdl_data = '0; mdl_op = '0; mdl_off = '0;
        exp_q.delete();
    endtask

    // Entered just after a negedge; returns just after the negedge where the unit is IDLE again.
    task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdata, input int rdly, input int ddly, output obs_t o);
        int          wcnt;
        int          rcnt;
        bit          hs;
        bit          sent;
        logic [31:0] w;
        o = '{default: 0};
        o.stable = 1'b1;
        check("issue_ready_idle", issue_ready, 1);
        issue_valid     = 1'b1;
        opcode          = op;
        addr            = a;
        store_data      = sd;
        mem_req_ready   = 1'($urandom_range(0, 1));
        mem_rdata_valid = 1'($urandom_range(0, 1));
        mem_rdata       = $urandom;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        opcode      = 6'($urandom);
        addr        = $urandom;
        store_data  = $urandom;
        wcnt = 0; rcnt = 0; hs = 1'b0; sent = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (ld_valid) begin
                o.ld_cnt++; o.ld_k = k; o.ld_op = ld_opcode; o.ld_off = ld_byte_offset;
                if (exp_q.size() == 0) check("ld_unexpected", ld_valid, 0);
                else begin
                    w = exp_q.pop_front();
                    check("ld_data", ld_data, w);
                end
            end
            if (st_done) begin o.st_cnt++; o.st_k = k; end
            if (addr_misaligned) o.mis_cnt++;
`ifdef MEM_TIMEOUT_EN
            if (mem_timeout) o.to_cnt++;
`endif
            if (mem_req_valid) begin
                if (o.req_cnt == 0) begin
                    o.req_cnt = 1; o.req_addr = mem_addr; o.req_we = mem_we; o.req_wdata = mem_wdata;
                end else if (mem_addr !== o.req_addr || mem_we !== o.req_we || mem_wdata !== o.req_wdata) begin
                    o.stable = 1'b0;
                end
                if (issue_ready || hs) o.stable = 1'b0;
            end
            mem_req_ready   = 1'b0;
            mem_rdata_valid = 1'b0;
            mem_rdata       = $urandom;
            if (issue_ready) begin
                o.done = 1'b1;
                break;
            end
            if (mem_req_valid && !hs) begin
                if (wcnt >= rdly) begin
                    mem_req_ready = 1'b1;
                    hs = 1'b1;
                end else wcnt++;
                if ($urandom_range(0, 2) == 0) mem_rdata_valid = 1'b1;
            end else if (hs && !sent) begin
                if (rcnt >= ddly) begin
                    mem_rdata_valid = 1'b1;
                    mem_rdata       = rdata;
                    sent            = 1'b1;
                end else begin
                    rcnt++;
                    mem_req_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        check("txn_complete", o.done, 1);
        if (!o.done) do_reset();
    endtask

    task automatic judge(input string tag, input logic [5:0] op, input int rdly, input int ddly,
                         input exp_t e, input obs_t o);
        bit go;
        bit ld;
        bit st;
        bit to;
        int lat;
        go = (e.kind != 0) && !e.mis;
        ld = go && (e.kind == 1);
        st = go && (e.kind == 2);
        to = 1'b0;
`ifdef MEM_TIMEOUT_EN
        to = ld && (ddly >= TO);
        check({tag, "_timeout_pulses"}, o.to_cnt, to);
`endif
        check({tag, "_misaligned_pulses"}, o.mis_cnt, (e.kind != 0) && e.mis);
        check({tag, "_requests"}, o.req_cnt, go);
        if (go && o.req_cnt == 1) begin
            check({tag, "_mem_addr"}, o.req_addr, e.maddr);
            check({tag, "_mem_we"}, o.req_we, e.we);
            if (st) check({tag, "_mem_wdata"}, o.req_wdata, e.wdata);
            check({tag, "_req_protocol"}, o.stable, 1);
        end
        check({tag, "_st_done_pulses"}, o.st_cnt, st);
        if (st && o.st_cnt == 1) check({tag, "_st_done_cycle"}, o.st_k, 2 + rdly);
        check({tag, "_ld_valid_pulses"}, o.ld_cnt, ld);
        if (ld && o.ld_cnt == 1) begin
            lat = to ? (2 + rdly + TO) : (3 + rdly + ddly);
            check({tag, "_ld_latency"}, o.ld_k, lat);
            check({tag, "_ld_opcode"}, o.ld_op, op);
            check({tag, "_ld_byte_offset"}, o.ld_off, e.off);
            mdl_op  = op;
            mdl_off = e.off;
        end else if (!ld) begin
            check({tag, "_ld_data_hold"}, ld_data, mdl_data);
            check({tag, "_ld_opcode_hold"}, ld_opcode, mdl_op);
            check({tag, "_ld_offset_hold"}, ld_byte_offset, mdl_off);
        end
    endtask

    task automatic do_vec(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rdata, input int rdly,
                          input int ddly, input exp_t e);
        obs_t        o;
        logic [31:0] w;
        bit          ld;
        ld = (e.kind == 1) && !e.mis;
        w  = rdata;
`ifdef MEM_TIMEOUT_EN
        if (ddly >= TO) w = 32'hDEADBEEF;
`endif
        if (ld) exp_q.push_back(w);
        run_txn(op, a, sd, rdata, rdly, ddly, o);
        judge(tag, op, rdly, ddly, e, o);
        check({tag, "_exp_q_drained"}, exp_q.size(), 0);
        exp_q.delete();
        if (ld) mdl_data = w;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit          seen;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] sd;
        int          rdly;
        int          ddly;

        issue_valid = 1'b0; opcode = '0; addr = '0; store_data = '0;
        mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_issue_ready", issue_ready, 1);
        check("rst_state", dbg_state, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_ld_valid", ld_valid, 0);
        check("rst_ld_data", ld_data, 0);
        check("rst_ld_opcode", ld_opcode, 0);
        check("rst_ld_byte_offset", ld_byte_offset, 0);
        check("rst_st_done", st_done, 0);
        check("rst_addr_misaligned", addr_misaligned, 0);

        add_vec(6'h28, 32'h1003, 32'h000000AB, 32'h0, 0, 0, mk(2, 0, 32'h1000, 4'b0001, 32'hABABABAB, 2'd0));
        add_vec(6'h21, 32'h2002, 32'h0, 32'h11223344, 0, 2, mk(1, 0, 32'h2000, 4'b0000, 32'h0, 2'd1));
        add_vec(6'h23, 32'h3001, 32'h0, 32'h0, 0, 0, mk(1, 1, 32'h0, 4'b0000, 32'h0, 2'd0));
        add_vec(6'h2B, 32'h40, 32'hCAFEF00D, 32'h0, 5, 0, mk(2, 0, 32'h40, 4'b1111, 32'hCAFEF00D, 2'd0));
        add_vec(6'h29, 32'h1002, 32'h00001234, 32'h0, 1, 0, mk(2, 0, 32'h1000, 4'b0011, 32'h12341234, 2'd0));
        add_vec(6'h29, 32'h1000, 32'hFFFF5678, 32'h0, 0, 0, mk(2, 0, 32'h1000, 4'b1100, 32'h56785678, 2'd0));
        add_vec(6'h28, 32'h1000, 32'h123456CD, 32'h0, 2, 0, mk(2, 0, 32'h1000, 4'b1000, 32'hCDCDCDCD, 2'd0));
        add_vec(6'h28, 32'h1001, 32'h00000011, 32'h0, 0, 0, mk(2, 0, 32'h1000, 4'b0100, 32'h11111111, 2'd0));
        add_vec(6'h24, 32'h5001, 32'h0, 32'hA5A5A5A5, 0, 0, mk(1, 0, 32'h5000, 4'b0000, 32'h0, 2'd1));
        add_vec(6'h20, 32'h5002, 32'h0, 32'h01020304, 3, 1, mk(1, 0, 32'h5000, 4'b0000, 32'h0, 2'd2));
        add_vec(6'h25, 32'h6000, 32'h0, 32'h0BADF00D, 1, 0, mk(1, 0, 32'h6000, 4'b0000, 32'h0, 2'd0));
        add_vec(6'h23, 32'h8004, 32'h0, 32'h89ABCDEF, 0, 3, mk(1, 0, 32'h8004, 4'b0000, 32'h0, 2'd0));
        add_vec(6'h25, 32'h6003, 32'h0, 32'h0, 0, 0, mk(1, 1, 32'h0, 4'b0000, 32'h0, 2'd0));
        add_vec(6'h29, 32'h7001, 32'hFFFF, 32'h0, 0, 0, mk(2, 1, 32'h0, 4'b0000, 32'h0, 2'd0));
        add_vec(6'h2B, 32'h7002, 32'h1, 32'h0, 0, 0, mk(2, 1, 32'h0, 4'b0000, 32'h0, 2'd0));
        add_vec(6'h22, 32'h100, 32'h1, 32'h0, 0, 0, mk(0, 0, 32'h0, 4'b0000, 32'h0, 2'd0));
        add_vec(6'h20, 32'h5003, 32'h0, 32'h77665544, 0, 0, mk(1, 0, 32'h5000, 4'b0000, 32'h0, 2'd3));
        add_vec(6'h21, 32'h9000, 32'h0, 32'h00000001, 2, 2, mk(1, 0, 32'h9000, 4'b0000, 32'h0, 2'd0));

        for (int i = 0; i < vecs.size(); i++)
            do_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].sd, vecs[i].rdata,
                   vecs[i].rdly, vecs[i].ddly, vecs[i].e);

        for (int i = 0; i < 200; i++) begin
            op   = ops[$urandom_range(0, 10)];
            a    = $urandom;
            sd   = $urandom;
            rdly = $urandom_range(0, 3);
            ddly = $urandom_range(0, 3);
`ifdef MEM_TIMEOUT_EN
            if ($urandom_range(0, 7) == 0) ddly = TO + 2;
`endif
            do_vec($sformatf("rnd%0d", i), op, a, sd, $urandom, rdly, ddly, model(op, a, sd));
        end

        // Reset while waiting in RESP; a response arriving after release must be ignored.
        issue_valid = 1'b1; opcode = 6'h23; addr = 32'h200;
        @(posedge clk);
        #1 issue_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rstresp_state_before", dbg_state, 2);
        rst_n = 1'b0;
        #1;
        check("rstresp_outputs_zero",
              |{mem_req_valid, mem_addr, mem_we, mem_wdata, ld_valid, ld_data, ld_opcode,
                ld_byte_offset, st_done, addr_misaligned}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rdata_valid = 1'b1;
        mem_rdata = 32'h55AA55AA;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ld_valid) seen = 1'b1;
        end
        mem_rdata_valid = 1'b0;
        check("rstresp_no_ld_valid", seen, 0);
        check("rstresp_issue_ready", issue_ready, 1);
        check("rstresp_ld_data", ld_data, 0);
        check("rstresp_state_after", dbg_state, 0);
        mdl_data = '0; mdl_op = '0; mdl_off = '0;

        // Reset while a request is stalled in REQ: mem_req_valid drops without a clock edge.
        issue_valid = 1'b1; opcode = 6'h2B; addr = 32'h300; store_data = 32'h12345678;
        @(posedge clk);
        #1 issue_valid = 1'b0;
        @(negedge clk);
        check("rstreq_valid_before", mem_req_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rstreq_valid_drop", mem_req_valid, 0);
        check("rstreq_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_vec("post_reset_lw", 6'h23, 32'h400, 32'h0, 32'hFEEDFACE, 0, 0,
               mk(1, 0, 32'h400, 4'b0000, 32'h0, 2'd0));
`ifdef MEM_TIMEOUT_EN
        do_vec("timeout_lbu", 6'h24, 32'h13, 32'h0, 32'h12345678, 0, 100,
               mk(1, 0, 32'h10, 4'b0000, 32'h0, 2'd3));
        do_vec("expiry_tie_lhu", 6'h25, 32'h22, 32'h0, 32'h0A0B0C0D, 1, TO - 1,
               mk(1, 0, 32'h20, 4'b0000, 32'h0, 2'd1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
